// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if : handshake/data bundle between a synchronous FIFO and its user.
//   master : user side  (drives wr_data, wr_en, rd_en; sees data and status)
//   slave  : FIFO side  (returns rd_data, fill_count and status flags)
// Parameters: DATA_WIDTH (word width), ADDR_WIDTH (fill_count is ADDR_WIDTH+1).
// -----------------------------------------------------------------------------
interface sync_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   fill_count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_data, wr_en, rd_en,
      input  rd_data, fifo_full, fifo_empty, almost_full, almost_empty,
             fill_count, overflow, underflow
   );

   modport slave (
      input  wr_data, wr_en, rd_en,
      output rd_data, fifo_full, fifo_empty, almost_full, almost_empty,
             fill_count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with any depth >= 2 (non-power-of-two allowed),
//             occupancy counter, almost-full/empty thresholds and sticky
//             overflow/underflow flags.
// Ports:
//   clk  - clock, all state changes on rising edge
//   rst  - synchronous active-high reset (wins over wr_en/rd_en)
//   bus  - sync_fifo_if.slave: wr_data/wr_en/rd_en in; rd_data, fill_count,
//          fifo_full, fifo_empty, almost_full, almost_empty, overflow,
//          underflow out
// Build option:
//   SYNC_FIFO_FWFT_EN - first-word fall-through: rd_data shows the head word
//                       whenever the FIFO is non-empty. Undefined: rd_data is
//                       loaded one cycle after an accepted read.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned AFULL_THRESH  = 12,
   parameter int unsigned AEMPTY_THRESH = 4
) (
   input  logic       clk,
   input  logic       rst,
   sync_fifo_if.slave bus
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]      AFULL_CNT  = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0]      AEMPTY_CNT = CNT_W'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      fill_count;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  overflow;
   logic                  underflow;

   logic [ADDR_WIDTH-1:0] wr_ptr_nxt_c;
   logic [ADDR_WIDTH-1:0] rd_ptr_nxt_c;
   logic [CNT_W-1:0]      fill_count_nxt_c;
   logic                  full_c;
   logic                  empty_c;
   logic                  wr_ok_c;
   logic                  rd_ok_c;

   // Pointer advance with explicit wrap so odd depths never index past the array.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_IDX) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   // Status decoded from the count register only.
   assign full_c  = (fill_count == DEPTH_CNT);
   assign empty_c = (fill_count == '0);

   // Acceptance: on full, a simultaneous read still drains; on empty, the write still fills.
   assign wr_ok_c = bus.wr_en & ~full_c;
   assign rd_ok_c = bus.rd_en & ~empty_c;

   // Next pointer and count values.
   always_comb begin
      wr_ptr_nxt_c     = wr_ptr;
      rd_ptr_nxt_c     = rd_ptr;
      fill_count_nxt_c = fill_count;
      if (wr_ok_c) wr_ptr_nxt_c = ptr_inc(wr_ptr);
      if (rd_ok_c) rd_ptr_nxt_c = ptr_inc(rd_ptr);
      case ({wr_ok_c, rd_ok_c})
         2'b10:   fill_count_nxt_c = fill_count + CNT_W'(1);
         2'b01:   fill_count_nxt_c = fill_count - CNT_W'(1);
         default: fill_count_nxt_c = fill_count;
      endcase
   end

   // Storage array; not reset, stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok_c) mem[wr_ptr] <= bus.wr_data;
   end

   // Pointers, count, sticky error flags and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_count <= '0;
         rd_data    <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt_c;
         rd_ptr     <= rd_ptr_nxt_c;
         fill_count <= fill_count_nxt_c;
         if (bus.wr_en && full_c)  overflow  <= 1'b1;
         if (bus.rd_en && empty_c) underflow <= 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
         // Preload the next head word. When the new head is the slot being
         // written this edge, the memory still holds stale data, so bypass.
         if (fill_count_nxt_c != '0) begin
            if (wr_ok_c && (rd_ptr_nxt_c == wr_ptr)) rd_data <= bus.wr_data;
            else                                     rd_data <= mem[rd_ptr_nxt_c];
         end
`else
         if (rd_ok_c) rd_data <= mem[rd_ptr];
`endif
      end
   end

   assign bus.rd_data      = rd_data;
   assign bus.fill_count   = fill_count;
   assign bus.fifo_full    = full_c;
   assign bus.fifo_empty   = empty_c;
   assign bus.almost_full  = (fill_count >= AFULL_CNT);
   assign bus.almost_empty = (fill_count <= AEMPTY_CNT);
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo : directed self-checking bench for sync_fifo.
//   dut  - default configuration (depth 16, thresholds 12/4)
//   dut5 - depth 5, thresholds 4/1, for pointer wrap on a non-power-of-two depth
// Follows SYNC_FIFO_FWFT_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus  ();
   sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus5 ();

   sync_fifo dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   sync_fifo #(
      .DATA_WIDTH   (8),
      .FIFO_DEPTH   (5),
      .ADDR_WIDTH   (3),
      .AFULL_THRESH (4),
      .AEMPTY_THRESH(1)
   ) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5.slave)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] q5[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      bus.wr_data = d;
      bus.wr_en   = 1'b1;
      step();
      bus.wr_en   = 1'b0;
   endtask

   // Pop one word and compare it; in FWFT mode the word is visible before the pop.
   task automatic pop(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
      check(tag, 32'(bus.rd_data), 32'(exp));
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
`else
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check(tag, 32'(bus.rd_data), 32'(exp));
`endif
   endtask

   task automatic chk5(input string tag);
      check({tag, "_cnt"},  32'(bus5.fill_count),   32'(q5.size()));
      check({tag, "_full"}, 32'(bus5.fifo_full),    32'(q5.size() == 5));
      check({tag, "_af"},   32'(bus5.almost_full),  32'(q5.size() >= 4));
      check({tag, "_ae"},   32'(bus5.almost_empty), 32'(q5.size() <= 1));
   endtask

   task automatic w5(input logic [7:0] d);
      bus5.wr_data = d;
      bus5.wr_en   = 1'b1;
      step();
      bus5.wr_en   = 1'b0;
      q5.push_back(d);
      chk5("w5");
   endtask

   task automatic r5();
      logic [7:0] exp;
      exp = q5.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      check("r5_data", 32'(bus5.rd_data), 32'(exp));
      bus5.rd_en = 1'b1;
      step();
      bus5.rd_en = 1'b0;
`else
      bus5.rd_en = 1'b1;
      step();
      bus5.rd_en = 1'b0;
      check("r5_data", 32'(bus5.rd_data), 32'(exp));
`endif
      chk5("r5");
   endtask

   initial begin
      rst          = 1'b1;
      bus.wr_data  = '0;
      bus.wr_en    = 1'b0;
      bus.rd_en    = 1'b0;
      bus5.wr_data = '0;
      bus5.wr_en   = 1'b0;
      bus5.rd_en   = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_cnt",   32'(bus.fill_count),   32'd0);
      check("rst_empty", 32'(bus.fifo_empty),   32'd1);
      check("rst_full",  32'(bus.fifo_full),    32'd0);
      check("rst_ae",    32'(bus.almost_empty), 32'd1);
      check("rst_af",    32'(bus.almost_full),  32'd0);
      check("rst_rd",    32'(bus.rd_data),      32'd0);
      check("rst_ovf",   32'(bus.overflow),     32'd0);
      check("rst_unf",   32'(bus.underflow),    32'd0);
      check("rst5_empty", 32'(bus5.fifo_empty), 32'd1);

      // Fill 0x01..0x10; almost_full from 12, almost_empty through 4
      for (int i = 1; i <= 16; i++) begin
         push(8'(i));
         check("fill_cnt", 32'(bus.fill_count),   32'(i));
         check("fill_af",  32'(bus.almost_full),  32'(i >= 12));
         check("fill_ae",  32'(bus.almost_empty), 32'(i <= 4));
         check("fill_full", 32'(bus.fifo_full),   32'(i == 16));
      end
      check("fill_ovf", 32'(bus.overflow), 32'd0);

      // Write into full FIFO is dropped and flagged
      push(8'hAA);
      check("ovf_set", 32'(bus.overflow),   32'd1);
      check("ovf_cnt", 32'(bus.fill_count), 32'd16);

      // Drain in order; 0xAA must never appear
      for (int i = 1; i <= 16; i++) pop("drain", 8'(i));
      check("drain_empty", 32'(bus.fifo_empty), 32'd1);
      check("ovf_sticky",  32'(bus.overflow),   32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      step();
      check("rd_hold", 32'(bus.rd_data), 32'h10);
`endif

      // Empty with simultaneous write and read: write wins
      bus.wr_data = 8'h55;
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      step();
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      check("unf_set", 32'(bus.underflow),  32'd1);
      check("unf_cnt", 32'(bus.fill_count), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      check("unf_rd_hold", 32'(bus.rd_data), 32'h10);
`endif
      pop("unf_pop", 8'h55);
      check("unf_sticky", 32'(bus.underflow), 32'd1);

      // Full with simultaneous write and read: read wins
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
      check("full2", 32'(bus.fifo_full), 32'd1);
      bus.wr_data = 8'hEE;
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      check("fullrw_head", 32'(bus.rd_data), 32'h20);
`endif
      step();
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      check("fullrw_rd", 32'(bus.rd_data), 32'h20);
`endif
      check("fullrw_cnt",  32'(bus.fill_count), 32'd15);
      check("fullrw_full", 32'(bus.fifo_full),  32'd0);
      for (int i = 1; i < 16; i++) pop("fullrw_drain", 8'(8'h20 + i));
      check("fullrw_empty", 32'(bus.fifo_empty), 32'd1);

      // Mid-stream reset with a write pending: reset wins, everything clears
      for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
      check("pre_rst_cnt", 32'(bus.fill_count), 32'd8);
      rst         = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h77;
      step();
      rst         = 1'b0;
      bus.wr_en   = 1'b0;
      check("mrst_cnt",   32'(bus.fill_count), 32'd0);
      check("mrst_empty", 32'(bus.fifo_empty), 32'd1);
      check("mrst_ovf",   32'(bus.overflow),   32'd0);
      check("mrst_unf",   32'(bus.underflow),  32'd0);
      check("mrst_rd",    32'(bus.rd_data),    32'd0);

`ifdef SYNC_FIFO_FWFT_EN
      // Fall-through: word visible the cycle after the write, no rd_en needed
      push(8'h3C);
      check("fwft_rd",    32'(bus.rd_data),    32'h3C);
      check("fwft_cnt",   32'(bus.fill_count), 32'd1);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check("fwft_empty", 32'(bus.fifo_empty), 32'd1);
`endif

      // Depth 5: 12 writes interleaved with reads, wrapping both pointers
      for (int i = 0; i < 5; i++) w5(8'(8'h40 + i));
      for (int i = 0; i < 4; i++) r5();
      for (int i = 5; i < 9; i++) w5(8'(8'h40 + i));
      for (int i = 0; i < 5; i++) r5();
      for (int i = 9; i < 12; i++) w5(8'(8'h40 + i));
      for (int i = 0; i < 3; i++) r5();
      check("d5_empty", 32'(bus5.fifo_empty), 32'd1);
      check("d5_ovf",   32'(bus5.overflow),   32'd0);
      check("d5_unf",   32'(bus5.underflow),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the data word width in bits.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16, giving the number of storage slots; any value >= 2 is legal, including non-powers of two.
REQ-003 The module SHALL have parameter ADDR_WIDTH, default 4, equal to ceil(log2(FIFO_DEPTH)).
REQ-004 The module SHALL have parameter AFULL_THRESH, default 12, the fill level at and above which almost_full asserts.
REQ-005 The module SHALL have parameter AEMPTY_THRESH, default 4, the fill level at and below which almost_empty asserts.
REQ-006 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-007 Port rst, input, 1 bit, SHALL be the reset, which is synchronous and active-high.
REQ-008 Port wr_data, input, DATA_WIDTH bits, SHALL carry the write word.
REQ-009 Port wr_en, input, 1 bit, SHALL be the write request.
REQ-010 Port rd_en, input, 1 bit, SHALL be the read request (pop).
REQ-011 Port rd_data, output, DATA_WIDTH bits, SHALL carry the read word.
REQ-012 Port fifo_full, output, 1 bit, SHALL be high when fill_count == FIFO_DEPTH.
REQ-013 Port fifo_empty, output, 1 bit, SHALL be high when fill_count == 0.
REQ-014 Port almost_full, output, 1 bit, SHALL be high when fill_count >= AFULL_THRESH.
REQ-015 Port almost_empty, output, 1 bit, SHALL be high when fill_count <= AEMPTY_THRESH.
REQ-016 Port fill_count, output, ADDR_WIDTH+1 bits, SHALL give the number of stored words (0..FIFO_DEPTH).
REQ-017 Port overflow, output, 1 bit, SHALL be a sticky flag: at least one write was rejected.
REQ-018 Port underflow, output, 1 bit, SHALL be a sticky flag: at least one read was rejected.

Function
REQ-019 A write SHALL be accepted when wr_en=1 and fifo_full=0: wr_data is stored at wr_ptr and wr_ptr advances.
REQ-020 A read SHALL be accepted when rd_en=1 and fifo_empty=0, and rd_ptr then advances.
REQ-021 wr_ptr and rd_ptr SHALL be ADDR_WIDTH bits and wrap from FIFO_DEPTH-1 to 0; they never index slots >= FIFO_DEPTH.
REQ-022 fill_count SHALL be a register: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
REQ-023 All status flags SHALL be decoded from the registered fill_count only, with no path from wr_en or rd_en.
REQ-024 When full with wr_en=1 and rd_en=1, the read SHALL be accepted, the write rejected, overflow set, and fill_count become FIFO_DEPTH-1.
REQ-025 When empty with wr_en=1 and rd_en=1, the write SHALL be accepted, the read rejected, underflow set, and fill_count become 1.
REQ-026 A rejected write SHALL NOT modify memory or wr_ptr; a rejected read SHALL NOT modify rd_data or rd_ptr.
REQ-027 overflow and underflow SHALL, once set, remain high until rst.
REQ-028 rd_data SHALL hold its last value whenever no read is accepted (non-FWFT mode).

Reset
REQ-029 With rst=1 at a rising clk edge: wr_ptr=0, rd_ptr=0, fill_count=0, rd_data=0, overflow=0, underflow=0.
REQ-030 After reset, outputs SHALL be: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
REQ-031 rst SHALL take priority over simultaneous wr_en/rd_en; a mid-stream reset discards all contents, and memory contents need not be cleared.

Configuration
REQ-032 Macro SYNC_FIFO_FWFT_EN SHALL select first-word fall-through mode.
REQ-033 With SYNC_FIFO_FWFT_EN defined, rd_data SHALL equal mem[rd_ptr] whenever fifo_empty=0 (valid before rd_en), and an accepted rd_en pops that word.
REQ-034 With SYNC_FIFO_FWFT_EN defined, the first word SHALL appear on rd_data one cycle after the write that makes the FIFO non-empty.
REQ-035 Without SYNC_FIFO_FWFT_EN, rd_data SHALL be registered and update one cycle after an accepted read (latency 1).

Verification
REQ-036 Reset then write 0x01..0x10 (depth 16) -> fill_count=16, fifo_full=1, almost_full asserts when count reaches 12, overflow=0.
REQ-037 Full FIFO, pulse wr_en with 0xAA -> overflow=1 sticky, fill_count stays 16; then read 16 words -> 0x01..0x10 in order, 0xAA never appears.
REQ-038 Empty FIFO, wr_en=rd_en=1 with 0x55 -> underflow=1, fill_count=1; next read returns 0x55.
REQ-039 FIFO_DEPTH=5: perform 12 writes interleaved with reads, keeping count <= 5 -> data order preserved across pointer wrap at 4->0, and fifo_full asserts exactly at count 5.
REQ-040 Fill to 8 then assert rst for one cycle -> next cycle fill_count=0, fifo_empty=1, overflow=0, underflow=0, rd_data=0.
REQ-041 With SYNC_FIFO_FWFT_EN defined, write 0x3C into empty FIFO -> rd_data=0x3C on the next cycle with rd_en=0; then rd_en=1 -> fifo_empty=1.
